pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the generic successor of the fixed-field stall/zero pipeline registers between CPU stages. It carries an arbitrary control bundle and data bundle, and it inserts bubbles on flush. Upstream readiness never depends combinationally on downstream readiness, so stages chain without long ready paths. Any inter-stage boundary (IF/ID … MEM/WB) instantiates it in place of a hand-written register.

## Interface
- DATA_W, 32, width of data bundle (ALU result, mem data, PC, …)
- CTRL_W, 4, width of control bundle (RegWrite, MemtoReg, …); forced to zero in bubbles
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  enable; low blocks new input, drain continues
- flush_i  in  1  synchronous flush, discards all held beats
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  stage can accept a beat
- in_ctrl_i  in  CTRL_W  upstream control bundle
- in_data_i  in  DATA_W  upstream data bundle
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts beat
- out_ctrl_o  out  CTRL_W  control bundle of head beat
- out_data_o  out  DATA_W  data bundle of head beat
- count_o  out  2  beats held (0, 1, 2)

## Operation
- Storage: main register (drives outputs) and skid register. State is encoded by count: EMPTY=0, ONE=1, TWO=2.
- Accept = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- in_ready_o = start_i & ~flush_i & (count != 2). Combinational from registered state and these two inputs only. There is no path from out_ready_i.
- out_valid_o = (count != 0), registered.
- EMPTY: accept -> main<=in, ONE. Otherwise stay.
- ONE: accept&pop -> main<=in, stay ONE. Accept&~pop -> skid<=in, TWO. Pop&~accept -> EMPTY. Neither -> hold.
- TWO: no accept possible. Pop -> main<=skid, ONE. Otherwise hold.
- Bubble rule: whenever count becomes 0, main ctrl and data are cleared to 0. out_ctrl_o and out_data_o are 0 whenever out_valid_o=0.
- Skid register contents are don't-care when not occupied. They are cleared on reset and flush.
- Order is strictly FIFO. No beat is dropped or duplicated except by flush.
- Flush (flush_i=1 at an edge): count<=0, main and skid cleared.
  - A beat presented at out_valid_o in the flush cycle with out_ready_i=1 counts as transferred.
  - No input handshake occurs in a flush cycle, because in_ready_o=0.
- start_i=0: in_ready_o=0. Held beats still pop normally.
- Reset (rst_i low, any time, asynchronous): count=0, out_valid_o=0, out_ctrl_o=0, out_data_o=0, skid=0. Reset takes priority over flush and all handshakes.

## Timing
- Latency: a beat accepted at edge N appears on out_* in the cycle after edge N (1 cycle) when the stage was EMPTY, or ONE with a simultaneous pop.
- Throughput: 1 beat/cycle sustained when out_ready_i=1.
- Backpressure: after out_ready_i falls, at most 2 beats are absorbed. in_ready_o falls in the cycle after the second beat is accepted.
- After out_ready_i rises in TWO: the first pop moves skid to main, and in_ready_o returns high the next cycle.
- Reset values: in_ready_o = start_i & ~flush_i, out_valid_o=0, out_ctrl_o=0, out_data_o=0, count_o=0.

## Test plan
- Reset:
  - Stimulus: assert rst_i=0 mid-stream with count=2, asynchronously between edges.
  - Response: out_valid_o, out_ctrl_o, out_data_o and count_o go to 0 immediately. After release, first beat 0xA5 is accepted and appears 1 cycle later.
- Streaming:
  - Stimulus: out_ready_i=1, in_valid_i=1, data 1,2,3,4 on consecutive cycles.
  - Response: out_data_o = 1,2,3,4 on consecutive cycles, 1-cycle latency, in_ready_o stays 1, count_o=1.
- Backpressure:
  - Stimulus: out_ready_i=0 for 4 cycles while data 10,11,12 are offered.
  - Response: 10 and 11 are accepted, count_o=2, in_ready_o=0. 12 is held upstream.
  - Stimulus: release out_ready_i.
  - Response: outputs 10,11,12 in order with no gap after the first pop.
- Flush:
  - Stimulus: with count_o=2 (ctrl=4'hF), pulse flush_i with in_valid_i=1.
  - Response: next cycle count_o=0, out_valid_o=0, out_ctrl_o=0, out_data_o=0. The incoming beat is not accepted, and in_ready_o returns to 1.
- Start gating:
  - Stimulus: start_i=0 with one beat (0x55) held and out_ready_i=1.
  - Response: 0x55 pops, in_ready_o=0 throughout, count_o goes to 0, and bubble outputs are 0.
- Simultaneous accept and pop in ONE:
  - Stimulus: simultaneous accept and pop in ONE state (main=7, in=8).
  - Response: main=8 and count_o stays 1 for the whole cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Upstream ready depends only on registered occupancy, start_i and flush_i, never on out_ready_i.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              accept, pop;

  assign in_ready_o  = start_i & ~flush_i & (state_q != ST_TWO);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Main register is zeroed whenever the stage empties, so bubbles drive 0.
  assign out_ctrl_o = main_ctrl_q;
  assign out_data_o = main_data_q;
  assign count_o    = 2'(state_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush_i) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          main_data_d = '0;
          skid_ctrl_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_skid;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i, flush_i;
  logic              in_valid_i, in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o, out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        count_o;

  always #5 clk_i = ~clk_i;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o), .count_o(count_o)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  beat_t       mq[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Compare outputs to the model, then advance the model across one clock edge.
  task automatic cycle();
    logic  exp_vld, exp_rdy;
    beat_t hd;
    #1;
    exp_vld = (mq.size() != 0);
    exp_rdy = start_i & ~flush_i & (mq.size() < 2);
    hd      = exp_vld ? mq[0] : '0;
    check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    check("out_valid", 64'(out_valid_o), 64'(exp_vld));
    check("out_ctrl", 64'(out_ctrl_o), 64'(hd.c));
    check("out_data", 64'(out_data_o), 64'(hd.d));
    check("count", 64'(count_o), 64'(mq.size()));
    if (flush_i) mq.delete();
    else begin
      if (exp_vld && out_ready_i) void'(mq.pop_front());
      if (in_valid_i && exp_rdy) mq.push_back({in_ctrl_i, in_data_i});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic ordy);
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    out_ready_i = ordy;
  endtask

  initial begin
    int unsigned nxt;
    logic        acc;
    rst_i = 1'b0; start_i = 1'b1; flush_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    rst_i = 1'b1;
    cycle();

    // Streaming 1..4 at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1);
    cycle(); cycle();

    // Backpressure: 10,11 absorbed, 12 held upstream
    nxt = 10;
    for (int i = 0; i < 4; i++) begin
      acc = (mq.size() < 2);
      drive(1'b1, 4'h3, DATA_W'(nxt), 1'b0);
      cycle();
      if (acc) nxt++;
    end
    check("bp_count", 64'(count_o), 64'd2);
    check("bp_ready", 64'(in_ready_o), 64'd0);
    check("bp_head", 64'(out_data_o), 64'd10);
    while (nxt <= 12) begin
      acc = (mq.size() < 2);
      drive(1'b1, 4'h3, DATA_W'(nxt), 1'b1);
      cycle();
      if (acc) nxt++;
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) cycle();

    // Flush with two held beats
    drive(1'b1, 4'hF, 32'hF0, 1'b0); cycle();
    drive(1'b1, 4'hF, 32'hF1, 1'b0); cycle();
    check("pre_flush_count", 64'(count_o), 64'd2);
    flush_i = 1'b1;
    drive(1'b1, 4'hF, 32'hF2, 1'b0);
    cycle();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_ctrl", 64'(out_ctrl_o), 64'd0);
    cycle();

    // Start gating: held 0x55 drains while input is blocked
    drive(1'b1, 4'h1, 32'h55, 1'b0); cycle();
    start_i = 1'b0;
    drive(1'b1, 4'h2, 32'h66, 1'b1);
    repeat (3) cycle();
    check("start_count", 64'(count_o), 64'd0);
    start_i = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    cycle();

    // Simultaneous accept and pop in ONE
    drive(1'b1, 4'h1, 32'd7, 1'b0); cycle();
    drive(1'b1, 4'h1, 32'd8, 1'b1); cycle();
    check("sim_data", 64'(out_data_o), 64'd8);
    check("sim_count", 64'(count_o), 64'd1);
    drive(1'b0, '0, '0, 1'b1);
    cycle();

    // Asynchronous reset with two beats held
    drive(1'b1, 4'h5, 32'h21, 1'b0); cycle();
    drive(1'b1, 4'h5, 32'h22, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_ctrl", 64'(out_ctrl_o), 64'd0);
    check("arst_data", 64'(out_data_o), 64'd0);
    mq.delete();
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    drive(1'b1, 4'h6, 32'hA5, 1'b1); cycle();
    drive(1'b0, '0, '0, 1'b1);
    check("arst_a5", 64'(out_data_o), 64'hA5);
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start_i = ($urandom_range(0, 15) != 0);
      flush_i = ($urandom_range(0, 31) == 0);
      drive(($urandom_range(0, 3) != 0), CTRL_W'($urandom), DATA_W'($urandom),
            ($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
